// File: rtl/delaybuffer_prog.sv
// Runtime-programmable token-count delay line with ready/valid handshakes.
// History lives in a circular buffer; the output is a single register stage.
module delaybuffer_prog #(
    parameter int width_p       = 8,
    parameter int max_delay_p   = 16,
    parameter int reset_delay_p = 8
) (
    input  logic                               clk_i,
    input  logic                               reset_ni,
    input  logic [$clog2(max_delay_p+1)-1:0]   delay_i,
    input  logic                               delay_load_i,
    input  logic [width_p-1:0]                 data_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    output logic [width_p-1:0]                 data_o,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [$clog2(max_delay_p+1)-1:0]   delay_o,
    output logic                               primed_o
);

    localparam int dw_lp = $clog2(max_delay_p + 1);
    localparam int dx_lp = dw_lp + 1;
    localparam int aw_lp = (max_delay_p > 1) ? $clog2(max_delay_p) : 1;
    localparam logic [dw_lp-1:0] max_d_lp   = dw_lp'(max_delay_p);
    localparam logic [dw_lp-1:0] reset_d_lp = dw_lp'(reset_delay_p);
    localparam logic [aw_lp-1:0] last_a_lp  = aw_lp'(max_delay_p - 1);

    logic [width_p-1:0] mem_q [max_delay_p];

    logic [dw_lp-1:0]   delay_q, delay_d;
    logic [dw_lp-1:0]   fill_q, fill_d;
    logic [aw_lp-1:0]   wr_ptr_q, wr_ptr_d;
    logic               valid_q, valid_d;
    logic [width_p-1:0] data_q, data_d;

    logic               in_fire, out_fire;
    logic [dx_lp-1:0]   wr_ext, delay_ext, rd_calc;
    logic [aw_lp-1:0]   rd_ptr;
    logic [width_p-1:0] result;

    assign ready_o  = (~valid_q | ready_i) & ~delay_load_i;
    assign in_fire  = valid_i & ready_o;
    assign out_fire = valid_q & ready_i;
    assign valid_o  = valid_q;
    assign data_o   = data_q;
    assign delay_o  = delay_q;
    assign primed_o = (fill_q >= delay_q);

    // Modular subtract without a divider so non power-of-2 depths work.
    assign wr_ext    = dx_lp'(wr_ptr_q);
    assign delay_ext = dx_lp'(delay_q);
    assign rd_calc   = (wr_ext < delay_ext) ? (wr_ext + dx_lp'(max_delay_p) - delay_ext)
                                            : (wr_ext - delay_ext);
    assign rd_ptr    = aw_lp'(rd_calc);

    always_comb begin
        result = '0;
        if (delay_q == '0) begin
            result = data_i;
        end else if (primed_o) begin
            result = mem_q[rd_ptr];
        end
    end

    always_comb begin
        delay_d  = delay_q;
        fill_d   = fill_q;
        wr_ptr_d = wr_ptr_q;
        valid_d  = valid_q;
        data_d   = data_q;
        if (delay_load_i) begin
            delay_d = (delay_i > max_d_lp) ? max_d_lp : delay_i;
            fill_d  = '0;
        end
        if (in_fire) begin
            wr_ptr_d = (wr_ptr_q == last_a_lp) ? '0 : wr_ptr_q + 1'b1;
            if (fill_q != max_d_lp) begin
                fill_d = fill_q + 1'b1;
            end
            valid_d = 1'b1;
            data_d  = result;
        end else if (out_fire) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            delay_q  <= reset_d_lp;
            fill_q   <= '0;
            wr_ptr_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            delay_q  <= delay_d;
            fill_q   <= fill_d;
            wr_ptr_q <= wr_ptr_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    // Storage is never reset; the fill count masks stale contents.
    always_ff @(posedge clk_i) begin
        if (in_fire) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: tb/tb_delaybuffer_prog.sv
// Directed bench for delaybuffer_prog: a history model feeds an expected-output
// queue on every accept, which is popped and compared on every output handshake.
module tb_delaybuffer_prog;

    logic       clk_i = 1'b0;
    logic       reset_ni;
    logic [4:0] delay_i;
    logic       delay_load_i;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic [4:0] delay_o;
    logic       primed_o;

    delaybuffer_prog #(.width_p(8), .max_delay_p(16), .reset_delay_p(8)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .delay_i(delay_i), .delay_load_i(delay_load_i),
        .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o),
        .valid_o(valid_o), .ready_i(ready_i), .delay_o(delay_o), .primed_o(primed_o)
    );

    always #5 clk_i = ~clk_i;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         d_model = 8;
    logic [7:0] hist[$];
    logic [7:0] expq[$];
    logic       prev_in = 1'b0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;
    int         n_accept = 0;
    int         n_out = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
        end
    endtask

    // Called #1 after a falling edge with inputs already applied.
    task automatic sample();
        logic       in_f, out_f;
        logic [7:0] expv, got;
        chk("delay_o", 32'(delay_o), 32'(d_model));
        chk("primed_o", 32'(primed_o), 32'(hist.size() >= d_model));
        if (prev_in) chk("latency_valid", 32'(valid_o), 32'd1);
        if (prev_hold) begin
            chk("hold_valid", 32'(valid_o), 32'd1);
            chk("hold_data", 32'(data_o), 32'(prev_data));
        end
        out_f = valid_o & ready_i;
        in_f  = valid_i & ready_o;
        if (out_f) begin
            n_out++;
            if (expq.size() == 0) begin
                chk("unexpected_output", 32'(data_o), 32'hffff_ffff);
            end else begin
                got = expq.pop_front();
                chk("data_o", 32'(data_o), 32'(got));
                $display("out #%0d data=%0h exp=%0h", n_out, data_o, got);
            end
        end
        if (in_f) begin
            if (d_model == 0) expv = data_i;
            else if (hist.size() < d_model) expv = '0;
            else expv = hist[hist.size() - d_model];
            expq.push_back(expv);
            hist.push_back(data_i);
            if (hist.size() > 32) void'(hist.pop_front());
            n_accept++;
        end
        if (delay_load_i) hist.delete();
        prev_in   = in_f;
        prev_hold = valid_o & ~ready_i;
        prev_data = data_o;
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        @(negedge clk_i);
        valid_i = v; data_i = d; ready_i = r; delay_load_i = 1'b0;
        #1;
        sample();
    endtask

    task automatic load(input logic [4:0] di, input logic r);
        @(negedge clk_i);
        delay_load_i = 1'b1; delay_i = di; valid_i = 1'b1; data_i = 8'hee; ready_i = r;
        #1;
        chk("ready_o_during_load", 32'(ready_o), 32'd0);
        sample();
        d_model = (di > 5'd16) ? 16 : int'(di);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
        chk("queue_empty", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        reset_ni = 1'b0; delay_i = '0; delay_load_i = 1'b0;
        data_i = '0; valid_i = 1'b0; ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_ni = 1'b1;
        #1;
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_data_o", 32'(data_o), 32'd0);
        chk("rst_delay_o", 32'(delay_o), 32'd8);
        chk("rst_primed_o", 32'(primed_o), 32'd0);
        chk("rst_ready_o", 32'(ready_o), 32'd1);

        // 1: default delay of 8
        for (int i = 1; i <= 20; i++) step(1'b1, 8'(i), 1'b1);
        chk("primed_after_20", 32'(primed_o), 32'd1);
        drain(3);

        // 2: zero delay passes data straight through
        load(5'd0, 1'b1);
        for (int i = 5; i <= 7; i++) step(1'b1, 8'(i), 1'b1);
        chk("d0_primed", 32'(primed_o), 32'd1);
        drain(3);

        // 3: full-depth delay exercises wrap and same-slot read-before-write
        load(5'd16, 1'b1);
        for (int i = 1; i <= 40; i++) step(1'b1, 8'(i), 1'b1);
        drain(3);

        // 4: random handshakes at delay 3
        load(5'd3, 1'b1);
        begin
            int start = n_accept;
            int cyc = 0;
            while (n_accept - start < 1000 && cyc < 20000) begin
                step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
                cyc++;
            end
            chk("random_budget", 32'(n_accept - start >= 1000), 32'd1);
        end
        drain(4);

        // 5: reload with the output stalled
        load(5'd4, 1'b1);
        for (int i = 1; i <= 10; i++) step(1'b1, 8'(i), 1'b1);
        step(1'b1, 8'd11, 1'b0);
        chk("stall_pending", 32'(valid_o), 32'd1);
        load(5'd2, 1'b0);
        for (int i = 20; i <= 23; i++) step(1'b1, 8'(i), 1'b1);
        chk("delay_o_2", 32'(delay_o), 32'd2);
        drain(3);

        // 6: clamp, then asynchronous reset mid-burst
        load(5'd31, 1'b1);
        step(1'b1, 8'h55, 1'b1);
        chk("delay_clamped", 32'(delay_o), 32'd16);
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b1);
        @(negedge clk_i);
        valid_i = 1'b0;
        #1;
        chk("pre_reset_valid", 32'(valid_o), 32'd1);
        reset_ni = 1'b0;
        #1;
        chk("async_rst_valid", 32'(valid_o), 32'd0);
        chk("async_rst_delay", 32'(delay_o), 32'd8);
        expq.delete(); hist.delete(); d_model = 8;
        prev_in = 1'b0; prev_hold = 1'b0;
        @(negedge clk_i);
        reset_ni = 1'b1;
        for (int i = 1; i <= 12; i++) step(1'b1, 8'(i + 100), 1'b1);
        drain(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
